// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions for the MUL/DIV sequencer and its datapath:
// state encoding, ALU opcodes and control-word bit positions.
package cpu_ctrl_pkg;

   typedef enum logic [3:0] {
      S_IDLE = 4'd0,
      S_T0   = 4'd1,
      S_T1   = 4'd2,
      S_T2   = 4'd3,
      S_T3   = 4'd4,
      S_T4   = 4'd5,
      S_T5   = 4'd6,
      S_T6   = 4'd7,
      S_DONE = 4'd8
   } state_t;

   localparam logic [4:0] OP_NONE = 5'd0;
   localparam logic [4:0] OP_ADD  = 5'd3;
   localparam logic [4:0] OP_SUB  = 5'd4;
   localparam logic [4:0] OP_AND  = 5'd5;
   localparam logic [4:0] OP_OR   = 5'd6;
   localparam logic [4:0] OP_SHR  = 5'd7;
   localparam logic [4:0] OP_SHL  = 5'd9;
   localparam logic [4:0] OP_NEG  = 5'd12;
   localparam logic [4:0] OP_NOT  = 5'd13;
   localparam logic [4:0] OP_MUL  = 5'd14;
   localparam logic [4:0] OP_DIV  = 5'd15;

   // Bus source selects occupy the low bits, register loads follow.
   localparam int unsigned CW_PC_OUT  = 0;
   localparam int unsigned CW_MDR_OUT = 1;
   localparam int unsigned CW_ZLO_OUT = 2;
   localparam int unsigned CW_ZHI_OUT = 3;
   localparam int unsigned CW_R6_OUT  = 4;
   localparam int unsigned CW_R7_OUT  = 5;
   localparam int unsigned CW_MAR_IN  = 6;
   localparam int unsigned CW_PC_EN   = 7;
   localparam int unsigned CW_PC_INC  = 8;
   localparam int unsigned CW_MDR_EN  = 9;
   localparam int unsigned CW_MDR_RD  = 10;
   localparam int unsigned CW_IR_EN   = 11;
   localparam int unsigned CW_Y_EN    = 12;
   localparam int unsigned CW_R6_EN   = 13;
   localparam int unsigned CW_R7_EN   = 14;
   localparam int unsigned CW_ZLO_EN  = 15;
   localparam int unsigned CW_ZHI_EN  = 16;
   localparam int unsigned CW_LO_EN   = 17;
   localparam int unsigned CW_HI_EN   = 18;
   localparam int unsigned CW_DONE    = 19;
   localparam int unsigned CW_W       = 20;

   typedef logic [CW_W-1:0] cw_t;

   function automatic cw_t cw_bit(input int unsigned idx);
      cw_bit = cw_t'(1) << idx;
   endfunction

endpackage

// File: rtl/mul_div_sequencer_if.sv
// Start/busy/done handshake plus every datapath control line the
// sequencer drives.
interface mul_div_sequencer_if;
   logic       start;
   logic       is_div;
   logic       busy;
   logic       done;
   logic       pc_out;
   logic       mdr_out;
   logic       zlo_out;
   logic       zhi_out;
   logic       r6_out;
   logic       r7_out;
   logic       mar_in;
   logic       pc_enable;
   logic       pc_increment;
   logic       mdr_enable;
   logic       mdr_read;
   logic       ir_enable;
   logic       y_enable;
   logic       r6_enable;
   logic       r7_enable;
   logic       zlo_enable;
   logic       zhi_enable;
   logic       lo_enable;
   logic       hi_enable;
   logic [4:0] op_code;

   modport master (
      output start, is_div,
      input  busy, done,
      input  pc_out, mdr_out, zlo_out, zhi_out, r6_out, r7_out,
      input  mar_in, pc_enable, pc_increment, mdr_enable, mdr_read,
      input  ir_enable, y_enable, r6_enable, r7_enable,
      input  zlo_enable, zhi_enable, lo_enable, hi_enable,
      input  op_code
   );

   modport slave (
      input  start, is_div,
      output busy, done,
      output pc_out, mdr_out, zlo_out, zhi_out, r6_out, r7_out,
      output mar_in, pc_enable, pc_increment, mdr_enable, mdr_read,
      output ir_enable, y_enable, r6_enable, r7_enable,
      output zlo_enable, zhi_enable, lo_enable, hi_enable,
      output op_code
   );
endinterface

// File: rtl/wait_counter.sv
// Loadable down-counter with zero flag; holds T4 while the clocked
// ALU settles.
module wait_counter #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!clr) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/mul_div_sequencer.sv
// Hard-wired T0..T6 control sequencer for MUL/DIV (R6 op R7 -> HI/LO).
// All outputs are Moore outputs decoded from the registered state.
module mul_div_sequencer
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned ALU_WAIT = 1
) (
   input  logic                  clk,
   input  logic                  clr,
   mul_div_sequencer_if.slave    ctrl
);

   state_t     state;
   state_t     state_nx;
   logic       div_q;
   cw_t        cw;
   logic [4:0] op;
   logic       cnt_load;
   logic       cnt_dec;
   logic       cnt_zero;

   wait_counter #(.W(4)) u_wait (
      .clk      (clk),
      .clr      (clr),
      .load     (cnt_load),
      .load_val (4'(ALU_WAIT)),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   always_ff @(posedge clk) begin
      if (!clr) begin
         state <= S_IDLE;
         div_q <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == S_IDLE && ctrl.start) begin
            div_q <= ctrl.is_div;
         end
      end
   end

   always_comb begin
      state_nx = state;
      cw       = '0;
      op       = OP_NONE;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (ctrl.start) state_nx = S_T0;
         end
         S_T0: begin
            cw = cw_bit(CW_PC_OUT) | cw_bit(CW_MAR_IN)
               | cw_bit(CW_PC_EN) | cw_bit(CW_PC_INC);
            state_nx = S_T1;
         end
         S_T1: begin
            cw = cw_bit(CW_MDR_RD) | cw_bit(CW_MDR_EN);
            state_nx = S_T2;
         end
         S_T2: begin
            cw = cw_bit(CW_MDR_OUT) | cw_bit(CW_IR_EN);
            state_nx = S_T3;
         end
         S_T3: begin
            cw = cw_bit(CW_R6_OUT) | cw_bit(CW_Y_EN);
            cnt_load = 1'b1;
            state_nx = S_T4;
         end
         S_T4: begin
            cw = cw_bit(CW_R7_OUT);
            op = div_q ? OP_DIV : OP_MUL;
            // Z is captured only once the ALU has had its settle cycles.
            if (cnt_zero) begin
               cw = cw | cw_bit(CW_ZLO_EN) | cw_bit(CW_ZHI_EN);
               state_nx = S_T5;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         S_T5: begin
            cw = cw_bit(CW_ZLO_OUT) | cw_bit(CW_LO_EN);
            state_nx = S_T6;
         end
         S_T6: begin
            cw = cw_bit(CW_ZHI_OUT) | cw_bit(CW_HI_EN);
            state_nx = S_DONE;
         end
         S_DONE: begin
            cw = cw_bit(CW_DONE);
            state_nx = S_IDLE;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   assign ctrl.busy         = (state != S_IDLE);
   assign ctrl.done         = cw[CW_DONE];
   assign ctrl.pc_out       = cw[CW_PC_OUT];
   assign ctrl.mdr_out      = cw[CW_MDR_OUT];
   assign ctrl.zlo_out      = cw[CW_ZLO_OUT];
   assign ctrl.zhi_out      = cw[CW_ZHI_OUT];
   assign ctrl.r6_out       = cw[CW_R6_OUT];
   assign ctrl.r7_out       = cw[CW_R7_OUT];
   assign ctrl.mar_in       = cw[CW_MAR_IN];
   assign ctrl.pc_enable    = cw[CW_PC_EN];
   assign ctrl.pc_increment = cw[CW_PC_INC];
   assign ctrl.mdr_enable   = cw[CW_MDR_EN];
   assign ctrl.mdr_read     = cw[CW_MDR_RD];
   assign ctrl.ir_enable    = cw[CW_IR_EN];
   assign ctrl.y_enable     = cw[CW_Y_EN];
   assign ctrl.r6_enable    = cw[CW_R6_EN];
   assign ctrl.r7_enable    = cw[CW_R7_EN];
   assign ctrl.zlo_enable   = cw[CW_ZLO_EN];
   assign ctrl.zhi_enable   = cw[CW_ZHI_EN];
   assign ctrl.lo_enable    = cw[CW_LO_EN];
   assign ctrl.hi_enable    = cw[CW_HI_EN];
   assign ctrl.op_code      = op;

endmodule

// File: tb/tb_mul_div_sequencer.sv
// Bench for mul_div_sequencer: one instance with ALU_WAIT=1 driving a small
// behavioural datapath, one with ALU_WAIT=0 for handshake timing.
module tb_mul_div_sequencer;

   logic clk = 1'b0;
   logic clr = 1'b0;
   always #5 clk = ~clk;

   mul_div_sequencer_if if1 ();
   mul_div_sequencer_if if0 ();

   mul_div_sequencer #(.ALU_WAIT(1)) dut1 (
      .clk  (clk),
      .clr  (clr),
      .ctrl (if1.slave)
   );

   mul_div_sequencer #(.ALU_WAIT(0)) dut0 (
      .clk  (clk),
      .clr  (clr),
      .ctrl (if0.slave)
   );

   // {sel[25:20] = pc,mdr,zlo,zhi,r6,r7 ; en[19:7] ; done[6] ; busy[5] ; op[4:0]}
   logic [25:0] o1, o0;
   assign o1 = {if1.pc_out, if1.mdr_out, if1.zlo_out, if1.zhi_out,
                if1.r6_out, if1.r7_out,
                if1.mar_in, if1.pc_enable, if1.pc_increment,
                if1.mdr_enable, if1.mdr_read, if1.ir_enable, if1.y_enable,
                if1.r6_enable, if1.r7_enable, if1.zlo_enable,
                if1.zhi_enable, if1.lo_enable, if1.hi_enable,
                if1.done, if1.busy, if1.op_code};
   assign o0 = {if0.pc_out, if0.mdr_out, if0.zlo_out, if0.zhi_out,
                if0.r6_out, if0.r7_out,
                if0.mar_in, if0.pc_enable, if0.pc_increment,
                if0.mdr_enable, if0.mdr_read, if0.ir_enable, if0.y_enable,
                if0.r6_enable, if0.r7_enable, if0.zlo_enable,
                if0.zhi_enable, if0.lo_enable, if0.hi_enable,
                if0.done, if0.busy, if0.op_code};

   // Behavioural datapath attached to dut1
   logic [31:0] r6, r7, y, lo, hi, zlo, zhi, dbus, alu_lo, alu_hi;
   logic [63:0] prod;
   logic signed [31:0] sy, sb;

   always_comb begin
      dbus = 32'd0;
      if (if1.r6_out)  dbus = r6;
      if (if1.r7_out)  dbus = r7;
      if (if1.zlo_out) dbus = zlo;
      if (if1.zhi_out) dbus = zhi;
   end

   always_comb begin
      sy     = y;
      sb     = dbus;
      prod   = {{32{y[31]}}, y} * {{32{dbus[31]}}, dbus};
      alu_lo = 32'd0;
      alu_hi = 32'd0;
      if (if1.op_code == 5'd14) begin
         alu_lo = prod[31:0];
         alu_hi = prod[63:32];
      end else if (if1.op_code == 5'd15 && sb != 0) begin
         alu_lo = sy / sb;
         alu_hi = sy % sb;
      end
   end

   always @(posedge clk) begin
      if (if1.y_enable)   y   <= dbus;
      if (if1.zlo_enable) zlo <= alu_lo;
      if (if1.zhi_enable) zhi <= alu_hi;
      if (if1.lo_enable)  lo  <= dbus;
      if (if1.hi_enable)  hi  <= dbus;
   end

   typedef struct {
      logic        dv;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] lo;
      logic [31:0] hi;
   } vec_t;

   typedef struct {
      logic [31:0] lo;
      logic [31:0] hi;
   } res_t;

   vec_t        vt [5];
   res_t        sbq [$];
   logic [25:0] exp_tr [10];

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic inv(input string name, input logic [25:0] o);
      n_vec++;
      if ($countones(o[25:20]) > 1 || (o[4:0] != 5'd0 && !o[20])) begin
         n_bad++;
         $display("FAIL %s invariant at %0t: got %h", name, $time, o);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      inv("dut1", o1);
      inv("dut0", o0);
   endtask

   initial begin
      int cyc;
      int t0_cnt;
      int d_cnt;
      int d_at [$];
      res_t r;

      vt[0] = '{1'b1, 32'h00000023, 32'h00000006, 32'h00000005, 32'h00000005};
      vt[1] = '{1'b0, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFA, 32'hFFFFFFFF};
      vt[2] = '{1'b0, 32'h00000007, 32'h00000006, 32'h0000002A, 32'h00000000};
      vt[3] = '{1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF};
      vt[4] = '{1'b0, 32'h00010000, 32'h00010000, 32'h00000000, 32'h00000001};

      exp_tr[0] = {6'b100000, 13'b1110000000000, 1'b0, 1'b1, 5'd0};
      exp_tr[1] = {6'b000000, 13'b0001100000000, 1'b0, 1'b1, 5'd0};
      exp_tr[2] = {6'b010000, 13'b0000010000000, 1'b0, 1'b1, 5'd0};
      exp_tr[3] = {6'b000010, 13'b0000001000000, 1'b0, 1'b1, 5'd0};
      exp_tr[4] = {6'b000001, 13'b0000000000000, 1'b0, 1'b1, 5'd14};
      exp_tr[5] = {6'b000001, 13'b0000000001100, 1'b0, 1'b1, 5'd14};
      exp_tr[6] = {6'b001000, 13'b0000000000010, 1'b0, 1'b1, 5'd0};
      exp_tr[7] = {6'b000100, 13'b0000000000001, 1'b0, 1'b1, 5'd0};
      exp_tr[8] = {6'b000000, 13'b0000000000000, 1'b1, 1'b1, 5'd0};
      exp_tr[9] = 26'd0;

      if1.start = 1'b0; if1.is_div = 1'b0;
      if0.start = 1'b0; if0.is_div = 1'b0;
      r6 = 32'd0; r7 = 32'd0;

      tick();
      tick();
      chk("reset_dut1", 64'(o1), 64'd0);
      chk("reset_dut0", 64'(o0), 64'd0);
      clr = 1'b1;

      // MUL control trace; is_div flips after acceptance
      if1.is_div = 1'b0;
      if1.start  = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (i == 0) begin
            if1.start  = 1'b0;
            if1.is_div = 1'b1;
         end
         chk($sformatf("mul_trace_c%0d", i + 1), 64'(o1), 64'(exp_tr[i]));
      end

      // Reset held two cycles in the middle of T4
      if1.is_div = 1'b1;
      if1.start  = 1'b1;
      tick();
      if1.start = 1'b0;
      cyc = 0;
      while (!o1[20] && cyc < 10) begin
         tick();
         cyc++;
      end
      chk("reach_t4", 64'(o1[20]), 64'd1);
      clr = 1'b0;
      tick();
      tick();
      clr = 1'b1;
      chk("midrun_reset", 64'(o1), 64'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("post_reset_idle%0d", i), 64'(o1), 64'd0);
      end

      // Datapath vectors through the scoreboard
      foreach (vt[k]) begin
         r6 = vt[k].a;
         r7 = vt[k].b;
         if1.is_div = vt[k].dv;
         if1.start  = 1'b1;
         sbq.push_back('{vt[k].lo, vt[k].hi});
         tick();
         if1.start  = 1'b0;
         if1.is_div = ~vt[k].dv;
         cyc = 1;
         while (!o1[6] && cyc < 40) begin
            tick();
            cyc++;
         end
         r = sbq.pop_front();
         if (!o1[6]) begin
            chk($sformatf("vec%0d_done_timeout", k), 64'd0, 64'd1);
         end else begin
            chk($sformatf("vec%0d_latency", k), 64'(cyc), 64'd9);
            chk($sformatf("vec%0d_lo", k), 64'(lo), 64'(r.lo));
            chk($sformatf("vec%0d_hi", k), 64'(hi), 64'(r.hi));
         end
         tick();
      end

      // start held high for 30 cycles on the ALU_WAIT=0 instance
      t0_cnt = 0;
      if0.start = 1'b1;
      for (int c = 1; c <= 30; c++) begin
         tick();
         if (o0[6]) d_at.push_back(c);
         if (o0[25]) t0_cnt++;
         if (c == 9 || c == 18) chk($sformatf("gap_idle_c%0d", c), 64'(o0[5]), 64'd0);
      end
      if0.start = 1'b0;
      chk("held_done_count", 64'(d_at.size()), 64'd3);
      chk("held_t0_count", 64'(t0_cnt), 64'd4);
      for (int i = 0; i < d_at.size() && i < 3; i++)
         chk($sformatf("held_done%0d_cycle", i), 64'(d_at[i]), 64'(8 + 9 * i));
      cyc = 30;
      while (!o0[6] && cyc < 45) begin
         tick();
         cyc++;
      end
      chk("held_last_done", 64'(cyc), 64'd35);
      tick();

      // start pulses during busy and in DONE are ignored
      d_cnt = 0;
      if0.start = 1'b1;
      for (int c = 1; c <= 30; c++) begin
         tick();
         if (o0[6]) d_cnt++;
         if (c == 12) chk("pulse_idle_c12", 64'(o0[5]), 64'd0);
         if0.start = (c == 3 || c == 5 || c == 8) ? 1'b1 : 1'b0;
      end
      chk("pulse_done_count", 64'(d_cnt), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
